// File: rtl/sdram_port_arbiter_if.sv
// Bundle for the two-client arbiter in front of the SDRAM controller burst port.
// slave = arbiter side, master = clients plus controller.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_wren;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W-1:0] a_to_mem;
  logic              a_ready;
  logic [2:0]        a_offset;
  logic              a_done;

  logic              b_req;
  logic              b_wren;
  logic [ADDR_W-1:0] b_address;
  logic [DATA_W-1:0] b_to_mem;
  logic              b_ready;
  logic [2:0]        b_offset;
  logic              b_done;

  // Read data goes straight from the controller to both clients.
  logic [DATA_W-1:0] from_mem;
  logic              mem_req;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_to_mem;
  logic              mem_ready;
  logic [2:0]        mem_offset;
  logic              busy;

  modport slave (
    input  a_req, a_wren, a_address, a_to_mem,
    input  b_req, b_wren, b_address, b_to_mem,
    input  mem_ready, mem_offset,
    output a_ready, a_offset, a_done,
    output b_ready, b_offset, b_done,
    output mem_req, mem_wren, mem_address, mem_to_mem, busy
  );

  modport master (
    output a_req, a_wren, a_address, a_to_mem,
    output b_req, b_wren, b_address, b_to_mem,
    output mem_ready, mem_offset, from_mem,
    input  a_ready, a_offset, a_done,
    input  b_ready, b_offset, b_done,
    input  mem_req, mem_wren, mem_address, mem_to_mem, busy
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller burst port between clients A and B.
// One single-cycle mem_req per transaction; address/direction held until the burst ends.
module sdram_port_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_port_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              last_b_q, last_b_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    gnt_a_d       = gnt_a_q;
    gnt_b_d       = gnt_b_q;
    last_b_d      = last_b_q;
    mem_req_d     = 1'b0;
    mem_wren_d    = mem_wren_q;
    mem_address_d = mem_address_q;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A wins outright, or on a tie when B was served last.
        if (bus.a_req && (!bus.b_req || last_b_q)) begin
          gnt_a_d       = 1'b1;
          mem_address_d = bus.a_address;
          mem_wren_d    = bus.a_wren;
          mem_req_d     = 1'b1;
          state_d       = S_ISSUE;
        end else if (bus.b_req) begin
          gnt_b_d       = 1'b1;
          mem_address_d = bus.b_address;
          mem_wren_d    = bus.b_wren;
          mem_req_d     = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ready) state_d = S_BURST;
      end
      S_BURST: begin
        if (!bus.mem_ready) begin
          state_d  = S_DONE;
          a_done_d = gnt_a_q;
          b_done_d = gnt_b_q;
        end
      end
      S_DONE: begin
        last_b_d = gnt_b_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      last_b_q      <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      last_b_q      <= last_b_d;
      mem_req_q     <= mem_req_d;
      mem_wren_q    <= mem_wren_d;
      mem_address_q <= mem_address_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_address = mem_address_q;
  assign bus.busy        = busy_q;
  assign bus.a_done      = a_done_q;
  assign bus.b_done      = b_done_q;

  // Burst handshake passes through with no added latency; ungranted side sees zeros.
  assign bus.a_ready    = bus.mem_ready & gnt_a_q;
  assign bus.b_ready    = bus.mem_ready & gnt_b_q;
  assign bus.a_offset   = gnt_a_q ? bus.mem_offset : 3'd0;
  assign bus.b_offset   = gnt_b_q ? bus.mem_offset : 3'd0;
  assign bus.mem_to_mem = gnt_a_q ? bus.a_to_mem :
                          gnt_b_q ? bus.b_to_mem : '0;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a cycle-scripted controller model.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int   req_pulses = 0;
  int   req_w      = 0;
  int   req_wmax   = 0;
  int   a_done_n   = 0;
  int   b_done_n   = 0;
  logic req_prev   = 1'b0;

  always @(negedge clk) begin
    req_prev <= bus.mem_req;
    if (bus.mem_req && !req_prev) req_pulses <= req_pulses + 1;
    req_w <= bus.mem_req ? req_w + 1 : 0;
    if (bus.mem_req && (req_w + 1 > req_wmax)) req_wmax <= req_w + 1;
    if (bus.a_done) a_done_n <= a_done_n + 1;
    if (bus.b_done) b_done_n <= b_done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_req", 32'(bus.mem_req), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  // Called in the cycle the arbiter should be in S_ISSUE.
  task automatic run_xfer(input bit is_a, input logic [ADDR_W-1:0] addr, input bit wren,
                          input int wait_n, input bit mutate, input bit drop, input int rst_beat);
    logic [7:0] exp_d;
    @(negedge clk);
    chk("issue_req", 32'(bus.mem_req), 32'd1);
    chk("issue_addr", 32'(bus.mem_address), 32'(addr));
    chk("issue_wren", 32'(bus.mem_wren), 32'(wren));
    chk("issue_busy", 32'(bus.busy), 32'd1);
    if (drop) begin
      if (is_a) bus.a_req = 1'b0;
      else      bus.b_req = 1'b0;
    end
    for (int w = 0; w < wait_n; w++) begin
      next();
      bus.mem_ready = 1'b0;
      if (mutate) begin
        bus.a_address = addr ^ 21'h15555;
        bus.a_wren    = ~wren;
      end
      @(negedge clk);
      chk("wait_req", 32'(bus.mem_req), 32'd0);
      chk("wait_addr", 32'(bus.mem_address), 32'(addr));
      chk("wait_wren", 32'(bus.mem_wren), 32'(wren));
      chk("wait_ready", 32'(bus.a_ready | bus.b_ready), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      next();
      bus.mem_ready  = 1'b1;
      bus.mem_offset = 3'(i);
      bus.from_mem   = 8'(8'hA0 + i);
      bus.a_to_mem   = 8'(8'h30 + i);
      bus.b_to_mem   = 8'(8'h50 + i);
      if (mutate) begin
        bus.a_address = addr ^ 21'(i + 1);
        bus.a_wren    = ~bus.a_wren;
      end
      if (i == rst_beat) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addr", 32'(bus.mem_address), 32'd0);
        chk("rst_wren", 32'(bus.mem_wren), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.a_ready | bus.b_ready), 32'd0);
        chk("rst_offset", 32'(bus.b_offset), 32'd0);
        chk("rst_done", 32'(bus.a_done | bus.b_done), 32'd0);
        return;
      end
      exp_d = is_a ? 8'(8'h30 + i) : 8'(8'h50 + i);
      @(negedge clk);
      chk("beat_ready", 32'(is_a ? bus.a_ready : bus.b_ready), 32'd1);
      chk("beat_offset", 32'(is_a ? bus.a_offset : bus.b_offset), 32'(i));
      chk("other_ready", 32'(is_a ? bus.b_ready : bus.a_ready), 32'd0);
      chk("other_offset", 32'(is_a ? bus.b_offset : bus.a_offset), 32'd0);
      chk("beat_wdata", 32'(bus.mem_to_mem), 32'(exp_d));
      chk("beat_addr", 32'(bus.mem_address), 32'(addr));
      chk("beat_wren", 32'(bus.mem_wren), 32'(wren));
      chk("beat_req", 32'(bus.mem_req), 32'd0);
    end
    next();
    bus.mem_ready  = 1'b0;
    bus.mem_offset = 3'd0;
    @(negedge clk);
    chk("tail_done", 32'(bus.a_done | bus.b_done), 32'd0);
    chk("tail_busy", 32'(bus.busy), 32'd1);
    chk("tail_addr", 32'(bus.mem_address), 32'(addr));
    next();
    @(negedge clk);
    chk("done_a", 32'(bus.a_done), 32'(is_a));
    chk("done_b", 32'(bus.b_done), 32'(!is_a));
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_req", 32'(bus.mem_req), 32'd0);
    chk("done_addr", 32'(bus.mem_address), 32'(addr));
  endtask

  int p0;
  int bd0;
  int ad0;

  initial begin
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_wren = 1'b0; bus.a_address = '0; bus.a_to_mem = '0;
    bus.b_req = 1'b0; bus.b_wren = 1'b0; bus.b_address = '0; bus.b_to_mem = '0;
    bus.from_mem = '0;
    bus.mem_ready = 1'b1;
    bus.mem_offset = 3'd5;
    #1;
    chk("reset_req", 32'(bus.mem_req), 32'd0);
    chk("reset_wren", 32'(bus.mem_wren), 32'd0);
    chk("reset_addr", 32'(bus.mem_address), 32'd0);
    chk("reset_done", 32'(bus.a_done | bus.b_done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_ready", 32'(bus.a_ready | bus.b_ready), 32'd0);
    chk("reset_offset", 32'({bus.a_offset, bus.b_offset}), 32'd0);
    bus.mem_ready = 1'b0;
    bus.mem_offset = 3'd0;
    @(negedge clk);
    rst = 1'b0;

    // Single A write
    next();
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_address = 21'h00010;
    idle_cycle();
    next();
    run_xfer(1'b1, 21'h00010, 1'b1, 2, 1'b0, 1'b0, -1);
    next();
    bus.a_req = 1'b0;
    idle_cycle();

    // Single B read
    next();
    bus.b_req = 1'b1; bus.b_wren = 1'b0; bus.b_address = 21'h1FFF8;
    idle_cycle();
    next();
    run_xfer(1'b0, 21'h1FFF8, 1'b0, 1, 1'b0, 1'b0, -1);
    next();
    bus.b_req = 1'b0;
    idle_cycle();

    // Tie: B was last, so A goes first
    p0 = req_pulses;
    next();
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_address = 21'h000F0;
    bus.b_req = 1'b1; bus.b_wren = 1'b0; bus.b_address = 21'h00F00;
    idle_cycle();
    next();
    run_xfer(1'b1, 21'h000F0, 1'b1, 0, 1'b0, 1'b0, -1);
    next();
    bus.a_req = 1'b0;
    idle_cycle();
    next();
    run_xfer(1'b0, 21'h00F00, 1'b0, 0, 1'b0, 1'b0, -1);
    next();
    bus.b_req = 1'b0;
    idle_cycle();
    chk("tie_pulses", 32'(req_pulses - p0), 32'd2);

    // Sustained contention, both requests held high
    p0 = req_pulses;
    next();
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_address = 21'h00100;
    bus.b_req = 1'b1; bus.b_wren = 1'b0; bus.b_address = 21'h00200;
    idle_cycle();
    for (int k = 0; k < 6; k++) begin
      next();
      run_xfer((k % 2) == 0, ((k % 2) == 0) ? 21'h00100 : 21'h00200, (k % 2) == 0,
               k % 3, 1'b0, 1'b0, -1);
      if (k < 5) begin
        next();
        idle_cycle();
      end
    end
    next();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    idle_cycle();
    chk("rr_pulses", 32'(req_pulses - p0), 32'd6);
    chk("rr_req_width", 32'(req_wmax), 32'd1);

    // Hold check: client A inputs wander after the grant
    next();
    bus.a_req = 1'b1; bus.a_wren = 1'b0; bus.a_address = 21'h0ABCD;
    idle_cycle();
    next();
    run_xfer(1'b1, 21'h0ABCD, 1'b0, 2, 1'b1, 1'b0, -1);
    next();
    bus.a_req = 1'b0;
    idle_cycle();

    // Reset at beat 4 of a B read (A was last, so only reset makes A win next)
    bd0 = b_done_n;
    next();
    bus.b_req = 1'b1; bus.b_wren = 1'b0; bus.b_address = 21'h1FFF8;
    idle_cycle();
    next();
    run_xfer(1'b0, 21'h1FFF8, 1'b0, 1, 1'b0, 1'b0, 4);
    bus.b_req = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_offset = 3'd0;
    #2 rst = 1'b0;
    next();
    idle_cycle();
    next();
    idle_cycle();
    chk("rst_no_bdone", 32'(b_done_n - bd0), 32'd0);

    // Tie after reset; A drops its request right after the grant
    ad0 = a_done_n;
    next();
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_address = 21'h00333;
    bus.b_req = 1'b1; bus.b_wren = 1'b0; bus.b_address = 21'h00444;
    idle_cycle();
    next();
    run_xfer(1'b1, 21'h00333, 1'b1, 0, 1'b0, 1'b1, -1);
    next();
    idle_cycle();
    next();
    run_xfer(1'b0, 21'h00444, 1'b0, 0, 1'b0, 1'b0, -1);
    next();
    bus.b_req = 1'b0;
    idle_cycle();
    chk("drop_adone", 32'(a_done_n - ad0), 32'd1);
    chk("final_req_width", 32'(req_wmax), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
